// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle processor control unit:
// opcodes, state encodings, datapath select codes and the control word.
package mc_ctrl_pkg;

    localparam logic [2:0] OP_RTYPE   = 3'b000;
    localparam logic [2:0] OP_LW      = 3'b001;
    localparam logic [2:0] OP_SW      = 3'b010;
    localparam logic [2:0] OP_BEQ     = 3'b011;
    localparam logic [2:0] OP_J       = 3'b100;
    localparam logic [2:0] OP_ADDI    = 3'b101;
    localparam logic [2:0] OP_ILLEGAL = 3'b110;
    localparam logic [2:0] OP_HALT    = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    // A memory wait must not commit architectural state; selects stay put.
    function automatic ctrl_t suppress_writes(input ctrl_t c);
        ctrl_t r;
        r               = c;
        r.pc_write      = 1'b0;
        r.pc_write_cond = 1'b0;
        r.ir_write      = 1'b0;
        r.reg_write     = 1'b0;
        r.mem_write     = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: maps the current state to the datapath control word.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        // NOTE: default the whole word first so every path assigns it and no latch is inferred.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNC;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            default:  ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle Moore control FSM for the 16-bit processor: state register,
// sequencing, stall/reset gating of the control word, flags and perf counters.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter bit ILLEGAL_HALTS = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       opcode,
    input  logic             stall,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic             halted,
    output logic             illegal_op,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q, state_d;
    logic [2:0]       opcode_q, opcode_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    ctrl_t            raw_ctrl, out_ctrl;

    mc_ctrl_decode u_decode (
        .state (state_q),
        .ctrl  (raw_ctrl)
    );

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        cycle_d   = cycle_q;
        instr_d   = instr_q;

        if (state_q != S_HALT) begin
            cycle_d = cycle_q + CNT_W'(1);
        end

        if (!stall) begin
            case (state_q)
                S_FETCH: begin
                    state_d = S_DECODE;
                    instr_d = instr_q + CNT_W'(1);
                end
                S_DECODE: begin
                    // Opcode is captured here so MEMADR does not depend on IR later.
                    opcode_d = opcode;
                    case (opcode)
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_HALT:      state_d = S_HALT;
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = ILLEGAL_HALTS ? S_HALT : S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_d = S_MEMWB;
                S_EXEC:   state_d = S_RWB;
                S_ADDIEX: state_d = S_ADDIWB;
                S_HALT:   state_d = S_HALT;
                default:  state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        out_ctrl = raw_ctrl;
        if (stall) begin
            out_ctrl = suppress_writes(raw_ctrl);
        end
        if (!reset) begin
            out_ctrl = '0;
        end
    end

    // NOTE: reset is synchronous, so it is sampled inside the clocked block only.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            opcode_q  <= OP_RTYPE;
            illegal_q <= 1'b0;
            cycle_q   <= '0;
            instr_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop updates from the same pre-edge values.
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
        end
    end

    assign PCWrite     = out_ctrl.pc_write;
    assign PCWriteCond = out_ctrl.pc_write_cond;
    assign IorD        = out_ctrl.iord;
    assign MemRead     = out_ctrl.mem_read;
    assign MemWrite    = out_ctrl.mem_write;
    assign MemtoReg    = out_ctrl.mem_to_reg;
    assign IRWrite     = out_ctrl.ir_write;
    assign ALUSrcA     = out_ctrl.alu_src_a;
    assign RegWrite    = out_ctrl.reg_write;
    assign RegDst      = out_ctrl.reg_dst;
    assign ALUOp       = out_ctrl.alu_op;
    assign ALUSrcB     = out_ctrl.alu_src_b;
    assign PCSource    = out_ctrl.pc_source;

    assign halted      = reset && (state_q == S_HALT);
    assign illegal_op  = illegal_q;
    assign state_dbg   = state_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: an instruction-path model compared every
// cycle, plus hand-computed spot checks for each instruction class and corner case.
module tb_mc_control_unit;

    localparam int CNT_W = 4;

    // Control word bit positions used by the bench.
    localparam int B_PCW  = 15;
    localparam int B_PCWC = 14;
    localparam int B_IORD = 13;
    localparam int B_MRD  = 12;
    localparam int B_MWR  = 11;
    localparam int B_M2R  = 10;
    localparam int B_IRW  = 9;
    localparam int B_SRCA = 8;
    localparam int B_RW   = 7;
    localparam int B_RDST = 6;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             stall = 1'b0;
    logic [2:0]       opcode = 3'b000;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic             IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0]       ALUOp, ALUSrcB, PCSource;
    logic             halted, illegal_op;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] cycle_count, instr_count;
    logic [15:0]      dut_ctrl;

    int               n_checks = 0;
    int               n_errors = 0;
    bit               chk_en = 1'b0;

    // Model: which instruction path we are on and how far along it.
    int               m_op = -1;
    int               m_idx = 0;
    logic [CNT_W-1:0] m_cycle = '0;
    logic [CNT_W-1:0] m_instr = '0;
    logic             m_illegal = 1'b0;

    always #5 clock = ~clock;

    mc_control_unit #(
        .CNT_W         (CNT_W),
        .ILLEGAL_HALTS (1'b0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .stall       (stall),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .state_dbg   (state_dbg),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                       ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource};

    // Number of states an instruction visits, FETCH included.
    function automatic int path_len(input int op);
        case (op)
            0: return 4;
            1: return 5;
            2: return 4;
            3: return 3;
            4: return 3;
            5: return 4;
            7: return 3;
            default: return 2;
        endcase
    endfunction

    // State visited at step i of the instruction with opcode op.
    function automatic int path_state(input int op, input int i);
        if (i == 0) return 0;
        if (i == 1) return 1;
        case (op)
            0: return (i == 2) ? 6 : 7;
            1: return (i == 2) ? 2 : ((i == 3) ? 3 : 4);
            2: return (i == 2) ? 2 : 5;
            3: return 8;
            4: return 9;
            5: return (i == 2) ? 10 : 11;
            7: return 12;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] ctrl_of(input int s);
        logic [15:0] c;
        c = '0;
        case (s)
            0:  begin c[B_PCW] = 1'b1; c[B_MRD] = 1'b1; c[B_IRW] = 1'b1; c[3:2] = 2'b01; end
            1:  c[3:2] = 2'b11;
            2:  begin c[B_SRCA] = 1'b1; c[3:2] = 2'b10; end
            3:  begin c[B_MRD] = 1'b1; c[B_IORD] = 1'b1; end
            4:  begin c[B_RW] = 1'b1; c[B_M2R] = 1'b1; end
            5:  begin c[B_MWR] = 1'b1; c[B_IORD] = 1'b1; end
            6:  begin c[B_SRCA] = 1'b1; c[5:4] = 2'b10; end
            7:  begin c[B_RW] = 1'b1; c[B_RDST] = 1'b1; end
            8:  begin c[B_SRCA] = 1'b1; c[5:4] = 2'b01; c[B_PCWC] = 1'b1; c[1:0] = 2'b01; end
            9:  begin c[B_PCW] = 1'b1; c[1:0] = 2'b10; end
            10: begin c[B_SRCA] = 1'b1; c[3:2] = 2'b10; end
            11: c[B_RW] = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic int exp_state();
        return path_state(m_op, m_idx);
    endfunction

    function automatic logic [15:0] exp_ctrl();
        logic [15:0] c;
        c = ctrl_of(exp_state());
        if (stall) begin
            c[B_PCW]  = 1'b0;
            c[B_PCWC] = 1'b0;
            c[B_IRW]  = 1'b0;
            c[B_RW]   = 1'b0;
            c[B_MWR]  = 1'b0;
        end
        if (!reset) c = '0;
        return c;
    endfunction

    function automatic logic exp_halted();
        return reset && (exp_state() == 12);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented this cycle.
    task automatic model_update();
        int cur;
        if (!reset) begin
            m_op      = -1;
            m_idx     = 0;
            m_cycle   = '0;
            m_instr   = '0;
            m_illegal = 1'b0;
        end else begin
            cur = path_state(m_op, m_idx);
            if (cur != 12) begin
                m_cycle = m_cycle + 1'b1;
                if (!stall) begin
                    if (m_idx == 0) m_instr = m_instr + 1'b1;
                    if (m_idx == 1) begin
                        m_op = int'(opcode);
                        if (opcode == 3'b110) m_illegal = 1'b1;
                    end
                    m_idx++;
                    if (m_idx >= path_len(m_op)) m_idx = 0;
                end
            end
        end
    endtask

    // One clock cycle with the given inputs; returns 2 time units after the edge.
    task automatic step(input logic r, input logic s, input logic [2:0] o);
        reset  = r;
        stall  = s;
        opcode = o;
        @(posedge clock);
        model_update();
        chk_en = 1'b1;
        #2;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("ctrl", 32'(dut_ctrl), 32'(exp_ctrl()));
            check("state_dbg", 32'(state_dbg), 32'(exp_state()));
            check("cycle_count", 32'(cycle_count), 32'(m_cycle));
            check("instr_count", 32'(instr_count), 32'(m_instr));
            check("illegal_op", 32'(illegal_op), 32'(m_illegal));
            check("halted", 32'(halted), 32'(exp_halted()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held three cycles.
        repeat (3) step(1'b0, 1'b0, 3'b000);
        check("rst_ctrl_zero", 32'(dut_ctrl), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_cycle", 32'(cycle_count), 32'd0);
        check("rst_instr", 32'(instr_count), 32'd0);

        // R-type: 0,1,6,7
        step(1'b1, 1'b0, 3'b000);
        check("r_decode_state", 32'(state_dbg), 32'd1);
        check("r_instr_at_decode", 32'(instr_count), 32'd1);
        repeat (2) step(1'b1, 1'b0, 3'b000);
        check("r_rwb_state", 32'(state_dbg), 32'd7);
        check("r_rwb_regwrite", 32'(RegWrite), 32'd1);
        check("r_rwb_regdst", 32'(RegDst), 32'd1);
        step(1'b1, 1'b0, 3'b000);

        // LW: 0,1,2,3,4
        repeat (3) step(1'b1, 1'b0, 3'b001);
        check("lw_memrd_state", 32'(state_dbg), 32'd3);
        check("lw_memrd_rd_iord", 32'({MemRead, IorD}), 32'b11);
        step(1'b1, 1'b0, 3'b001);
        check("lw_memwb_state", 32'(state_dbg), 32'd4);
        check("lw_memwb_m2r_rw", 32'({MemtoReg, RegWrite}), 32'b11);
        step(1'b1, 1'b0, 3'b001);

        // SW: 0,1,2,5
        repeat (3) step(1'b1, 1'b0, 3'b010);
        check("sw_memwr_state", 32'(state_dbg), 32'd5);
        check("sw_memwrite", 32'(MemWrite), 32'd1);
        step(1'b1, 1'b0, 3'b010);

        // BEQ: 0,1,8 then J: 0,1,9
        repeat (2) step(1'b1, 1'b0, 3'b011);
        check("beq_state", 32'(state_dbg), 32'd8);
        check("beq_pcwc_pcsrc", 32'({PCWriteCond, PCSource}), 32'b101);
        step(1'b1, 1'b0, 3'b011);
        repeat (2) step(1'b1, 1'b0, 3'b100);
        check("j_state", 32'(state_dbg), 32'd9);
        check("j_pcw_pcsrc", 32'({PCWrite, PCSource}), 32'b110);
        step(1'b1, 1'b0, 3'b100);

        // Stall in EXEC for two cycles, then once more in RWB.
        repeat (2) step(1'b1, 1'b0, 3'b000);
        repeat (2) step(1'b1, 1'b1, 3'b000);
        check("stall_exec_state", 32'(state_dbg), 32'd6);
        check("stall_cycle_count", 32'(cycle_count), 32'd7);
        check("stall_instr_count", 32'(instr_count), 32'd6);
        step(1'b1, 1'b0, 3'b000);
        step(1'b1, 1'b1, 3'b000);
        check("stall_rwb_state", 32'(state_dbg), 32'd7);
        check("stall_rwb_regwrite", 32'(RegWrite), 32'd0);
        stall = 1'b0;
        #1;
        check("unstall_rwb_regwrite", 32'(RegWrite), 32'd1);
        step(1'b1, 1'b0, 3'b000);

        // Illegal opcode returns to FETCH and sets the sticky flag.
        repeat (2) step(1'b1, 1'b0, 3'b110);
        check("illegal_state", 32'(state_dbg), 32'd0);
        check("illegal_flag", 32'(illegal_op), 32'd1);

        // ADDI: 0,1,10,11; flag stays set.
        repeat (4) step(1'b1, 1'b0, 3'b101);
        check("illegal_sticky", 32'(illegal_op), 32'd1);

        // HALT: counter freezes, stall has no effect.
        repeat (3) step(1'b1, 1'b0, 3'b111);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_cycle", 32'(cycle_count), 32'd2);
        check("halt_instr", 32'(instr_count), 32'd9);
        step(1'b1, 1'b1, 3'b111);
        step(1'b1, 1'b0, 3'b000);
        check("halt_cycle_frozen", 32'(cycle_count), 32'd2);
        check("halt_state_held", 32'(state_dbg), 32'd12);

        // Reset out of HALT, set the flag again, then reset mid-LW with stall asserted.
        step(1'b0, 1'b0, 3'b000);
        repeat (2) step(1'b1, 1'b0, 3'b110);
        repeat (3) step(1'b1, 1'b0, 3'b001);
        check("midlw_state", 32'(state_dbg), 32'd3);
        step(1'b0, 1'b1, 3'b001);
        check("midlw_reset_state", 32'(state_dbg), 32'd0);
        check("midlw_reset_illegal", 32'(illegal_op), 32'd0);
        check("midlw_reset_cycle", 32'(cycle_count), 32'd0);
        check("midlw_reset_ctrl", 32'(dut_ctrl), 32'd0);

        repeat (4) step(1'b1, 1'b0, 3'b000);
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
